mz_pulse_scheduler: RTL and testbench

Programmable sequencer for the Mach-Zehnder RF gate on the MKR Vidor 4000 FPGA. On a trigger from the Arduino pin it runs a configurable number of pi/2 – wait – pi – wait – pi/2 shots and drives the RF controller gate, replacing hard-coded durations with registers written by the host. It sits between the host register bus / trigger pin and the `rf` output pin.

---
 rtl/mz_seq_pkg.sv | 33 +++
 rtl/sync_edge.sv | 39 +++
 rtl/mz_pulse_scheduler.sv | 147 ++++++++++++++
 tb/tb_mz_pulse_scheduler.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mz_seq_pkg.sv
// Shared state encoding, register map and default durations for the
// Mach-Zehnder pulse scheduler.
package mz_seq_pkg;

    typedef logic [2:0] state_t;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_PRE  = 3'd1;
    localparam logic [2:0] ST_P1   = 3'd2;
    localparam logic [2:0] ST_W1   = 3'd3;
    localparam logic [2:0] ST_P2   = 3'd4;
    localparam logic [2:0] ST_W2   = 3'd5;
    localparam logic [2:0] ST_P3   = 3'd6;
    localparam logic [2:0] ST_HOLD = 3'd7;

    localparam logic [2:0] ADDR_PRE    = 3'd0;
    localparam logic [2:0] ADDR_PI2    = 3'd1;
    localparam logic [2:0] ADDR_WAIT   = 3'd2;
    localparam logic [2:0] ADDR_PI     = 3'd3;
    localparam logic [2:0] ADDR_HOLD   = 3'd4;
    localparam logic [2:0] ADDR_NSHOTS = 3'd5;

    localparam int unsigned DEF_PRE  = 400;
    localparam int unsigned DEF_PI2  = 333;
    localparam int unsigned DEF_WAIT = 66600;
    localparam int unsigned DEF_PI   = 666;
    localparam int unsigned DEF_HOLD = 33300;

    function automatic logic is_pulse(input state_t st);
        return (st == ST_P1) || (st == ST_P2) || (st == ST_P3);
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer; with EDGE set, the output is a one-cycle pulse on
// the synchronized rising edge, otherwise the synchronized level.
module sync_edge
    import mz_seq_pkg::*;
#(
    parameter bit EDGE = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_q
);

    logic r_s1, r_s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= i_async;
            r_s2 <= r_s1;
        end
    end

    generate
        if (EDGE) begin : g_edge
            logic r_s3;
            always_ff @(posedge clk) begin
                if (rst) r_s3 <= 1'b0;
                else     r_s3 <= r_s2;
            end
            assign o_q = r_s2 & ~r_s3;
        end else begin : g_level
            assign o_q = r_s2;
        end
    endgenerate

endmodule

// File: rtl/mz_pulse_scheduler.sv
// Host-programmable pi/2 - wait - pi - wait - pi/2 sequencer driving the RF
// gate; staging registers are latched into active copies at each run start.
module mz_pulse_scheduler
    import mz_seq_pkg::*;
#(
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned SHOT_W   = 16,
    parameter int unsigned PRE_DEF  = DEF_PRE,
    parameter int unsigned PI2_DEF  = DEF_PI2,
    parameter int unsigned WAIT_DEF = DEF_WAIT,
    parameter int unsigned PI_DEF   = DEF_PI,
    parameter int unsigned HOLD_DEF = DEF_HOLD
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trig,
    input  logic              abort,
    input  logic              cfg_we,
    input  logic [2:0]        cfg_addr,
    input  logic [CNT_W-1:0]  cfg_wdata,
    output logic              rf,
    output logic              busy,
    output logic              done,
    output logic [SHOT_W-1:0] shot_cnt
);

    logic [CNT_W-1:0]  r_stg_pre, r_stg_pi2, r_stg_wait, r_stg_pi, r_stg_hold;
    logic [SHOT_W-1:0] r_stg_nsh;
    logic [CNT_W-1:0]  r_act_pre, r_act_pi2, r_act_wait, r_act_pi, r_act_hold;
    logic [SHOT_W-1:0] r_act_nsh;
    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_rf, r_busy, r_done;
    logic [SHOT_W-1:0] r_shot_cnt;

    logic              w_start, w_abort;
    state_t            w_next_state;
    logic [CNT_W-1:0]  w_next_len;
    logic [SHOT_W-1:0] w_shot_inc;

    // A zero duration still occupies one cycle.
    function automatic logic [CNT_W-1:0] load_val(input logic [CNT_W-1:0] d);
        return (d == '0) ? '0 : d - CNT_W'(1);
    endfunction

    sync_edge #(.EDGE(1'b1)) u_trig_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (trig),
        .o_q     (w_start)
    );

    sync_edge #(.EDGE(1'b0)) u_abort_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (abort),
        .o_q     (w_abort)
    );

    assign w_shot_inc = (&r_shot_cnt) ? r_shot_cnt : r_shot_cnt + SHOT_W'(1);

    always_comb begin
        w_next_state = ST_IDLE;
        w_next_len   = r_act_pre;
        case (r_state)
            ST_PRE:  begin w_next_state = ST_P1;   w_next_len = r_act_pi2;  end
            ST_P1:   begin w_next_state = ST_W1;   w_next_len = r_act_wait; end
            ST_W1:   begin w_next_state = ST_P2;   w_next_len = r_act_pi;   end
            ST_P2:   begin w_next_state = ST_W2;   w_next_len = r_act_wait; end
            ST_W2:   begin w_next_state = ST_P3;   w_next_len = r_act_pi2;  end
            ST_P3:   begin w_next_state = ST_HOLD; w_next_len = r_act_hold; end
            ST_HOLD: begin w_next_state = ST_PRE;  w_next_len = r_act_pre;  end
            default: begin w_next_state = ST_IDLE; w_next_len = r_act_pre;  end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stg_pre  <= CNT_W'(PRE_DEF);
            r_stg_pi2  <= CNT_W'(PI2_DEF);
            r_stg_wait <= CNT_W'(WAIT_DEF);
            r_stg_pi   <= CNT_W'(PI_DEF);
            r_stg_hold <= CNT_W'(HOLD_DEF);
            r_stg_nsh  <= SHOT_W'(1);
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_rf       <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_shot_cnt <= '0;
        end else begin
            if (cfg_we) begin
                case (cfg_addr)
                    ADDR_PRE:    r_stg_pre  <= cfg_wdata;
                    ADDR_PI2:    r_stg_pi2  <= cfg_wdata;
                    ADDR_WAIT:   r_stg_wait <= cfg_wdata;
                    ADDR_PI:     r_stg_pi   <= cfg_wdata;
                    ADDR_HOLD:   r_stg_hold <= cfg_wdata;
                    ADDR_NSHOTS: r_stg_nsh  <= cfg_wdata[SHOT_W-1:0];
                    default: ;
                endcase
            end
            r_done <= 1'b0;
            // Abort outranks both phase exit and the end-of-shot decision.
            if ((r_state != ST_IDLE) && w_abort) begin
                r_state <= ST_IDLE;
                r_rf    <= 1'b0;
                r_busy  <= 1'b0;
            end else if (r_state == ST_IDLE) begin
                if (w_start) begin
                    r_act_pre  <= r_stg_pre;
                    r_act_pi2  <= r_stg_pi2;
                    r_act_wait <= r_stg_wait;
                    r_act_pi   <= r_stg_pi;
                    r_act_hold <= r_stg_hold;
                    r_act_nsh  <= (r_stg_nsh == '0) ? SHOT_W'(1) : r_stg_nsh;
                    r_cnt      <= load_val(r_stg_pre);
                    r_shot_cnt <= '0;
                    r_busy     <= 1'b1;
                    r_state    <= ST_PRE;
                end
            end else if (r_cnt != '0) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end else if (r_state == ST_HOLD) begin
                r_shot_cnt <= w_shot_inc;
                if (w_shot_inc == r_act_nsh) begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end else begin
                    r_state <= ST_PRE;
                    r_cnt   <= load_val(r_act_pre);
                end
            end else begin
                r_state <= w_next_state;
                r_cnt   <= load_val(w_next_len);
                r_rf    <= is_pulse(w_next_state);
            end
        end
    end

    assign rf       = r_rf;
    assign busy     = r_busy;
    assign done     = r_done;
    assign shot_cnt = r_shot_cnt;

endmodule

// File: tb/tb_mz_pulse_scheduler.sv
// Bench for mz_pulse_scheduler: captured per-cycle outputs are compared with
// waveforms computed arithmetically from the programmed durations.
module tb_mz_pulse_scheduler;

    localparam int P_PRE  = 40;
    localparam int P_PI2  = 33;
    localparam int P_WAIT = 66;
    localparam int P_PI   = 66;
    localparam int P_HOLD = 33;
    localparam int MAXN   = 1024;

    logic        clk = 1'b0;
    logic        rst, trig, abort, cfg_we;
    logic [2:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic        rf, busy, done;
    logic [15:0] shot_cnt;

    always #5 clk = ~clk;

    mz_pulse_scheduler #(
        .CNT_W(32), .SHOT_W(16),
        .PRE_DEF(P_PRE), .PI2_DEF(P_PI2), .WAIT_DEF(P_WAIT),
        .PI_DEF(P_PI), .HOLD_DEF(P_HOLD)
    ) dut (
        .clk(clk), .rst(rst), .trig(trig), .abort(abort),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .rf(rf), .busy(busy), .done(done), .shot_cnt(shot_cnt)
    );

    typedef struct {
        int pre; int pi2; int wt; int pi; int hold; int nsh;
    } cfg_t;

    cfg_t        stg;
    logic [18:0] c_vec [MAXN];
    logic [18:0] e_vec [MAXN];
    logic [18:0] bad_act, bad_exp;
    int          n_chk = 0;
    int          n_pass = 0;
    int          ev_wr_idx = -1, ev_ab_idx = -1, ev_rst_idx = -1, ev_tlo = -1, ev_thi = -1;
    logic [2:0]  ev_wr_addr = 3'd0;
    logic [31:0] ev_wr_data = 32'd0;

    function automatic int eff(input int v);
        return (v <= 0) ? 1 : v;
    endfunction

    function automatic int shot_len(input cfg_t c);
        return eff(c.pre) + 2*eff(c.pi2) + 2*eff(c.wt) + eff(c.pi) + eff(c.hold);
    endfunction

    // Outputs {rf,busy,done,shot_cnt} one sample after edge i, for a run whose
    // trigger is first seen at edge k (k < 0: no run in this window).
    function automatic logic [18:0] run_pt(input cfg_t c, input int i, input int k, input int prev);
        int s, l, n, e, j, o, p, a, w, q;
        logic r;
        if (k < 0 || i < k + 2) return {3'b000, 16'(prev)};
        s = k + 2; l = shot_len(c); n = eff(c.nsh); e = s + n*l;
        if (i == e) return {3'b001, 16'(n)};
        if (i > e)  return {3'b000, 16'(n)};
        j = (i - s) / l; o = (i - s) % l;
        p = eff(c.pre); a = eff(c.pi2); w = eff(c.wt); q = eff(c.pi);
        r = (o >= p && o < p+a) || (o >= p+a+w && o < p+a+w+q) ||
            (o >= p+a+2*w+q && o < p+2*a+2*w+q);
        return {r, 1'b1, 1'b0, 16'(j)};
    endfunction

    task automatic build_expect(input cfg_t c, input int n, input int k, input int prev);
        logic [18:0] t;
        for (int i = 0; i < n; i++) begin
            if (ev_rst_idx >= 0 && i > ev_rst_idx) begin
                e_vec[i] = '0;
            end else if (ev_ab_idx >= 0 && i >= ev_ab_idx + 3) begin
                t = run_pt(c, ev_ab_idx + 2, k, prev);
                e_vec[i] = {3'b000, t[15:0]};
            end else begin
                e_vec[i] = run_pt(c, i, k, prev);
            end
        end
    endtask

    function automatic int first_bad(input int n);
        for (int i = 0; i < n; i++) begin
            if (c_vec[i] !== e_vec[i]) begin
                bad_act = c_vec[i];
                bad_exp = e_vec[i];
                return i;
            end
        end
        return -1;
    endfunction

    task automatic capture(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            c_vec[i]  = {rf, busy, done, shot_cnt};
            cfg_we    = (i == ev_wr_idx);
            cfg_addr  = ev_wr_addr;
            cfg_wdata = ev_wr_data;
            if (i == ev_ab_idx) abort = 1'b1;
            rst = (i == ev_rst_idx);
            if (i == ev_tlo) trig = 1'b0;
            if (i == ev_thi) trig = 1'b1;
        end
        cfg_we = 1'b0; abort = 1'b0; rst = 1'b0;
        ev_wr_idx = -1; ev_ab_idx = -1; ev_rst_idx = -1; ev_tlo = -1; ev_thi = -1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic set_stg(input logic [2:0] a, input int d);
        case (a)
            3'd0: stg.pre  = d;
            3'd1: stg.pi2  = d;
            3'd2: stg.wt   = d;
            3'd3: stg.pi   = d;
            3'd4: stg.hold = d;
            3'd5: stg.nsh  = d % 65536;
            default: ;
        endcase
    endtask

    task automatic write_cfg(input logic [2:0] a, input int d);
        cfg_addr = a; cfg_wdata = d; cfg_we = 1'b1;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        set_stg(a, d);
    endtask

    task automatic stg_defaults();
        stg.pre = P_PRE; stg.pi2 = P_PI2; stg.wt = P_WAIT;
        stg.pi = P_PI; stg.hold = P_HOLD; stg.nsh = 1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        n_chk++; if (rf !== 1'b0) $display("FAIL reset_rf got %b want 0", rf); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
        n_chk++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else n_pass++;
        n_chk++; if (shot_cnt !== 16'd0) $display("FAIL reset_shot_cnt got %0d want 0", shot_cnt); else n_pass++;
        rst = 1'b0;
        idle(2);
        stg_defaults();
    endtask

    task automatic test_defaults();
        int n, bad;
        n = 2 + eff(stg.nsh) * shot_len(stg) + 4;
        build_expect(stg, n, 0, 0);
        trig = 1'b1; capture(n); trig = 1'b0;
        bad = first_bad(n); n_chk++;
        if (bad != -1) $display("FAIL default_wave cycle %0d got %h want %h", bad, bad_act, bad_exp);
        else n_pass++;
        n_chk++; if (shot_cnt !== 16'd1) $display("FAIL default_shot_cnt got %0d want 1", shot_cnt); else n_pass++;
        idle(5);
    endtask

    task automatic test_multi_shot();
        int n, bad;
        write_cfg(3'd0, 2); write_cfg(3'd1, 3); write_cfg(3'd2, 5);
        write_cfg(3'd3, 6); write_cfg(3'd4, 4); write_cfg(3'd5, 3);
        n = 2 + 3 * shot_len(stg) + 4;
        build_expect(stg, n, 0, 1);
        trig = 1'b1; capture(n); trig = 1'b0;
        bad = first_bad(n); n_chk++;
        if (bad != -1) $display("FAIL multi_wave cycle %0d got %h want %h", bad, bad_act, bad_exp);
        else n_pass++;
        n_chk++; if (shot_cnt !== 16'd3) $display("FAIL multi_shot_cnt got %0d want 3", shot_cnt); else n_pass++;
        idle(5);
    endtask

    task automatic test_cfg_during_run();
        int n, bad;
        write_cfg(3'd5, 1);
        n = 2 + shot_len(stg) + 4;
        build_expect(stg, n, 0, 3);
        ev_wr_idx = 2 + eff(stg.pre) + eff(stg.pi2) + 1;
        ev_wr_addr = 3'd3; ev_wr_data = 32'd10;
        trig = 1'b1; capture(n); trig = 1'b0;
        bad = first_bad(n); n_chk++;
        if (bad != -1) $display("FAIL cfg_old_run cycle %0d got %h want %h", bad, bad_act, bad_exp);
        else n_pass++;
        set_stg(3'd3, 10);
        idle(5);
        n = 2 + shot_len(stg) + 4;
        build_expect(stg, n, 0, 1);
        trig = 1'b1; capture(n); trig = 1'b0;
        bad = first_bad(n); n_chk++;
        if (bad != -1) $display("FAIL cfg_new_run cycle %0d got %h want %h", bad, bad_act, bad_exp);
        else n_pass++;
        idle(5);
    endtask

    task automatic test_abort();
        int n, bad, l;
        write_cfg(3'd5, 3);
        l = shot_len(stg);
        n = 2 + 3 * l + 4;
        ev_ab_idx = 2 + l + eff(stg.pre) + eff(stg.pi2) + 1;
        build_expect(stg, n, 0, 1);
        trig = 1'b1; capture(n); trig = 1'b0;
        bad = first_bad(n); n_chk++;
        if (bad != -1) $display("FAIL abort_wave cycle %0d got %h want %h", bad, bad_act, bad_exp);
        else n_pass++;
        n_chk++; if (shot_cnt !== 16'd1) $display("FAIL abort_shot_cnt got %0d want 1", shot_cnt); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL abort_busy got %b want 0", busy); else n_pass++;
        idle(5);
    endtask

    task automatic test_trig_held();
        int n, bad;
        write_cfg(3'd5, 1);
        n = 2 + shot_len(stg) + 20;
        build_expect(stg, n, 0, 1);
        trig = 1'b1; capture(n);
        bad = first_bad(n); n_chk++;
        if (bad != -1) $display("FAIL held_first cycle %0d got %h want %h", bad, bad_act, bad_exp);
        else n_pass++;
        build_expect(stg, 30, -1, 1);
        capture(30);
        bad = first_bad(30); n_chk++;
        if (bad != -1) $display("FAIL held_no_retrig cycle %0d got %h want %h", bad, bad_act, bad_exp);
        else n_pass++;
        n = 9 + shot_len(stg) + 4;
        ev_tlo = 3; ev_thi = 6;
        build_expect(stg, n, 7, 1);
        capture(n); trig = 1'b0;
        bad = first_bad(n); n_chk++;
        if (bad != -1) $display("FAIL held_second cycle %0d got %h want %h", bad, bad_act, bad_exp);
        else n_pass++;
        idle(5);
    endtask

    task automatic test_zero_and_reset();
        int n, bad;
        write_cfg(3'd1, 0); write_cfg(3'd5, 0);
        n = 2 + shot_len(stg) + 4;
        build_expect(stg, n, 0, 1);
        trig = 1'b1; capture(n); trig = 1'b0;
        bad = first_bad(n); n_chk++;
        if (bad != -1) $display("FAIL zero_wave cycle %0d got %h want %h", bad, bad_act, bad_exp);
        else n_pass++;
        idle(5);
        ev_rst_idx = 2 + eff(stg.pre) + 1 + eff(stg.wt) + 1;
        ev_tlo = 3;
        n = ev_rst_idx + 6;
        build_expect(stg, n, 0, 1);
        trig = 1'b1; capture(n); trig = 1'b0;
        bad = first_bad(n); n_chk++;
        if (bad != -1) $display("FAIL rst_mid_run cycle %0d got %h want %h", bad, bad_act, bad_exp);
        else n_pass++;
        stg_defaults();
        idle(5);
        n = 2 + shot_len(stg) + 4;
        build_expect(stg, n, 0, 0);
        trig = 1'b1; capture(n); trig = 1'b0;
        bad = first_bad(n); n_chk++;
        if (bad != -1) $display("FAIL rst_defaults_run cycle %0d got %h want %h", bad, bad_act, bad_exp);
        else n_pass++;
        idle(5);
    endtask

    task automatic test_random();
        int n, bad, prev;
        prev = 1;
        for (int it = 0; it < 4; it++) begin
            write_cfg(3'd0, int'($urandom_range(4, 8)));
            write_cfg(3'd1, int'($urandom_range(0, 5)));
            write_cfg(3'd2, int'($urandom_range(0, 5)));
            write_cfg(3'd3, int'($urandom_range(0, 5)));
            write_cfg(3'd4, int'($urandom_range(0, 5)));
            write_cfg(3'd5, int'($urandom_range(0, 3)));
            write_cfg(3'd6, int'($urandom_range(0, 1000)));
            write_cfg(3'd7, int'($urandom_range(0, 1000)));
            n = 2 + eff(stg.nsh) * shot_len(stg) + 4;
            ev_tlo = 5; ev_thi = 8;
            build_expect(stg, n, 0, prev);
            trig = 1'b1; capture(n); trig = 1'b0;
            bad = first_bad(n); n_chk++;
            if (bad != -1) $display("FAIL random_run%0d cycle %0d got %h want %h", it, bad, bad_act, bad_exp);
            else n_pass++;
            prev = eff(stg.nsh);
            idle(5);
        end
    endtask

    initial begin
        rst = 1'b1; trig = 1'b0; abort = 1'b0; cfg_we = 1'b0;
        cfg_addr = 3'd0; cfg_wdata = 32'd0;
        stg_defaults();
        test_reset();
        test_defaults();
        test_multi_shot();
        test_cfg_during_run();
        test_abort();
        test_trig_held();
        test_zero_and_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
